simt_mask_stack: RTL and testbench
==================================

// Module: simt_mask_stack
// PURPOSE
//  Parametrised divergence/reconvergence mask stack for the scheduler.
//  Holds the active-lane mask that gates each core's execution.
//  - push: enters a divergent branch.
//  - comp: switches to the else side of the current branch.
//  - pop: reconverges to the enclosing mask.
//  Adds configurable lanes/depth, stored parent masks, status outputs and sticky error flags.
// PARAMETERS
//  N_LANES  4  lanes (cores) per mask; instantiated with `N_CORES
//  DEPTH    8  max nesting levels (entries); >=1
//  CW       $clog2(DEPTH+1)  width of depth count (derived localparam)
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  reset        in   1        synchronous, active-low reset
//  pred         in   N_LANES  branch predicate per lane, sampled with push
//  push         in   1        enter branch
//  comp         in   1        switch to complementary branch side
//  pop          in   1        leave branch / reconverge
//  clr_err      in   1        clear sticky error flags
//  active_mask  out  N_LANES  current active lanes (registered)
//  any_active   out  1        |active_mask
//  depth        out  CW       number of valid entries
//  full         out  1        depth==DEPTH
//  empty        out  1        depth==0
//  ovf          out  1        sticky: push attempted while full
//  unf          out  1        sticky: pop/comp attempted while empty
//  multi        out  1        sticky: >1 of push/comp/pop in one cycle
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): active_mask=all 1s, depth=0, ovf=unf=multi=0.
//    Overrides every other input, including mid-stack; entry contents don't care.
//  - Entry i holds parent[i]: the active_mask at the time of its push.
//  - One-cycle latency: an op sampled at edge k is visible on outputs after edge k.
//  - Ops are only legal one-hot. Exactly one of push/comp/pop high:
//    . push, !full: parent[depth] <= active_mask; active_mask <= active_mask & pred; depth+1.
//    . comp, !empty: active_mask <= parent[depth-1] & ~active_mask.
//      Toggles taken/else side; two comps restore the original side.
//    . pop, !empty: active_mask <= parent[depth-1]; depth-1.
//  - Illegal ops change no state except the flag:
//    . push while full: ovf<=1.
//    . comp/pop while empty: unf<=1.
//  - Two or more of push/comp/pop high: no op performed, multi<=1.
//  - pred==0 on push is legal: active_mask becomes 0 and any_active=0.
//    comp then yields the full parent mask.
//  - clr_err: flags <=0; a new error event in the same cycle wins (flag set).
//  - Outputs:
//    . full, empty, any_active: combinational from registered state.
//    . No combinational path from inputs to outputs.
//  - Depth storage: register array DEPTH x N_LANES; no wrap-around (depth saturates).
// TESTING (N_LANES=4 unless stated)
//  1 reset low 2 cycles -> active=1111, depth=0, empty=1, full=0, flags=0.
//  2 push pred=1010 -> active=1010, depth=1; comp -> 0101; comp -> 1010;
//    pop -> active=1111, depth=0, empty=1.
//  3 push 1100, push 0110 -> active=0100, depth=2; comp -> 1000;
//    pop -> 1100; pop -> 1111.
//  4 DEPTH=2: push 1110, push 0111, push 0001 -> 3rd ignored:
//    active=0110, depth=2, full=1, ovf=1.
//  5 empty: pop -> unf=1, active=1111, depth=0; clr_err -> unf=0;
//    pop+clr_err same cycle -> unf=1.
//  6 push+pop same cycle at depth 1 -> multi=1, state unchanged;
//    reset low at depth 2 -> active=1111, depth=0, flags=0.

Source files
------------

// File: rtl/simt_mask_stack.sv
// rtl/simt_mask_stack.sv - SIMT divergence/reconvergence active-lane mask stack
module simt_mask_stack #(
    parameter  int N_LANES = 4,
    parameter  int DEPTH   = 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] pred,
    input  logic               push,
    input  logic               comp,
    input  logic               pop,
    input  logic               clr_err,
    output logic [N_LANES-1:0] active_mask,
    output logic               any_active,
    output logic [CW-1:0]      depth,
    output logic               full,
    output logic               empty,
    output logic               ovf,
    output logic               unf,
    output logic               multi
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N_LANES-1:0] parent [DEPTH];
    logic [1:0]         n_ops;
    logic               multi_ev;
    logic               do_push;
    logic               do_comp;
    logic               do_pop;
    logic [CW-1:0]      depth_m1;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;
    logic [N_LANES-1:0] top;

    assign n_ops    = {1'b0, push} + {1'b0, comp} + {1'b0, pop};
    assign multi_ev = (n_ops > 2'd1);

    assign full       = (depth == CW'(DEPTH));
    assign empty      = (depth == '0);
    assign any_active = |active_mask;

    assign do_push = push & ~multi_ev & ~full;
    assign do_comp = comp & ~multi_ev & ~empty;
    assign do_pop  = pop  & ~multi_ev & ~empty;

    assign depth_m1 = depth - CW'(1);
    assign wr_idx   = depth[IW-1:0];
    assign rd_idx   = depth_m1[IW-1:0];
    assign top      = parent[rd_idx];

    // Parent storage needs no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            parent[wr_idx] <= active_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_mask <= '1;
            depth       <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
            multi       <= 1'b0;
        end else begin
            if (do_push) begin
                active_mask <= active_mask & pred;
                depth       <= depth + CW'(1);
            end else if (do_comp) begin
                active_mask <= top & ~active_mask;
            end else if (do_pop) begin
                active_mask <= top;
                depth       <= depth_m1;
            end
            // A fresh error event in the clearing cycle keeps its flag set.
            ovf   <= (ovf   & ~clr_err) | (push & ~multi_ev & full);
            unf   <= (unf   & ~clr_err) | ((comp | pop) & ~multi_ev & empty);
            multi <= (multi & ~clr_err) | multi_ev;
        end
    end

endmodule

// File: tb/tb_simt_mask_stack.sv
// tb/tb_simt_mask_stack.sv - self-checking bench for simt_mask_stack (DEPTH 8 and DEPTH 2)
module tb_simt_mask_stack;

    // op word: {reset_n, clr_err, pop, comp, push}
    localparam logic [4:0] NOP  = 5'b10000;
    localparam logic [4:0] PUSH = 5'b10001;
    localparam logic [4:0] COMP = 5'b10010;
    localparam logic [4:0] POP  = 5'b10100;
    localparam logic [4:0] CLR  = 5'b11000;
    localparam logic [4:0] RST  = 5'b00000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pred = 4'h0;
    logic       push = 1'b0, comp = 1'b0, pop = 1'b0, clr_err = 1'b0;

    logic [3:0] a0, a1;
    logic [3:0] d0;
    logic [1:0] d1;
    logic       y0, f0, e0, o0, u0, m0;
    logic       y1, f1, e1, o1, u1, m1;

    int tests = 0;
    int fails = 0;

    logic [3:0] m_act [2];
    logic [3:0] m_stk [2][8];
    int         m_dep [2];
    bit         m_ovf [2];
    bit         m_unf [2];
    bit         m_mul [2];
    int         lim   [2] = '{8, 2};

    always #5 clk = ~clk;

    simt_mask_stack #(.N_LANES(4), .DEPTH(8)) dut0 (
        .clk(clk), .reset(reset), .pred(pred), .push(push), .comp(comp), .pop(pop),
        .clr_err(clr_err), .active_mask(a0), .any_active(y0), .depth(d0),
        .full(f0), .empty(e0), .ovf(o0), .unf(u0), .multi(m0)
    );

    simt_mask_stack #(.N_LANES(4), .DEPTH(2)) dut1 (
        .clk(clk), .reset(reset), .pred(pred), .push(push), .comp(comp), .pop(pop),
        .clr_err(clr_err), .active_mask(a1), .any_active(y1), .depth(d1),
        .full(f1), .empty(e1), .ovf(o1), .unf(u1), .multi(m1)
    );

    function automatic logic [13:0] exp_vec(input int k);
        return {m_act[k], 4'(m_dep[k]), m_dep[k] == lim[k], m_dep[k] == 0,
                |m_act[k], m_ovf[k], m_unf[k], m_mul[k]};
    endfunction

    task automatic model_update(input logic [3:0] pd, input logic [4:0] op);
        int n;
        n = int'(op[0]) + int'(op[1]) + int'(op[2]);
        for (int k = 0; k < 2; k++) begin
            if (!op[4]) begin
                m_act[k] = 4'hF;
                m_dep[k] = 0;
                m_ovf[k] = 0;
                m_unf[k] = 0;
                m_mul[k] = 0;
            end else begin
                if (op[3]) begin
                    m_ovf[k] = 0;
                    m_unf[k] = 0;
                    m_mul[k] = 0;
                end
                if (n > 1) begin
                    m_mul[k] = 1;
                end else if (op[0]) begin
                    if (m_dep[k] == lim[k]) m_ovf[k] = 1;
                    else begin
                        m_stk[k][m_dep[k]] = m_act[k];
                        m_dep[k]++;
                        m_act[k] = m_act[k] & pd;
                    end
                end else if (op[1]) begin
                    if (m_dep[k] == 0) m_unf[k] = 1;
                    else m_act[k] = m_stk[k][m_dep[k]-1] & ~m_act[k];
                end else if (op[2]) begin
                    if (m_dep[k] == 0) m_unf[k] = 1;
                    else begin
                        m_dep[k]--;
                        m_act[k] = m_stk[k][m_dep[k]];
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] pd, input logic [4:0] op);
        @(negedge clk);
        pred    = pd;
        push    = op[0];
        comp    = op[1];
        pop     = op[2];
        clr_err = op[3];
        reset   = op[4];
        @(posedge clk);
        model_update(pd, op);
        #1;
    endtask

    task automatic test_reset();
        step(4'h0, RST);
        step(4'h0, RST);
        tests++;
        if ({a0, d0, e0, f0, o0, u0, m0} !== {4'hF, 4'd0, 1'b1, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL reset_dut0 got=%b exp=%b", {a0, d0, e0, f0, o0, u0, m0}, {4'hF, 4'd0, 1'b1, 1'b0, 3'b000});
        end
        tests++;
        if ({a1, d1, e1, f1, o1, u1, m1} !== {4'hF, 2'd0, 1'b1, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL reset_dut1 got=%b exp=%b", {a1, d1, e1, f1, o1, u1, m1}, {4'hF, 2'd0, 1'b1, 1'b0, 3'b000});
        end
    endtask

    task automatic test_branch();
        step(4'b1010, PUSH);
        tests++;
        if ({a0, d0} !== {4'b1010, 4'd1}) begin
            fails++; $display("FAIL branch_push got=%b exp=%b", {a0, d0}, {4'b1010, 4'd1});
        end
        step(4'h0, COMP);
        tests++;
        if (a0 !== 4'b0101) begin
            fails++; $display("FAIL branch_comp1 got=%b exp=%b", a0, 4'b0101);
        end
        step(4'h0, COMP);
        tests++;
        if (a0 !== 4'b1010) begin
            fails++; $display("FAIL branch_comp2 got=%b exp=%b", a0, 4'b1010);
        end
        step(4'h0, POP);
        tests++;
        if ({a0, d0, e0} !== {4'b1111, 4'd0, 1'b1}) begin
            fails++; $display("FAIL branch_pop got=%b exp=%b", {a0, d0, e0}, {4'b1111, 4'd0, 1'b1});
        end
    endtask

    task automatic test_nested();
        step(4'b1100, PUSH);
        step(4'b0110, PUSH);
        tests++;
        if ({a0, d0} !== {4'b0100, 4'd2}) begin
            fails++; $display("FAIL nested_push got=%b exp=%b", {a0, d0}, {4'b0100, 4'd2});
        end
        step(4'h0, COMP);
        tests++;
        if (a0 !== 4'b1000) begin
            fails++; $display("FAIL nested_comp got=%b exp=%b", a0, 4'b1000);
        end
        step(4'h0, POP);
        tests++;
        if ({a0, d0} !== {4'b1100, 4'd1}) begin
            fails++; $display("FAIL nested_pop1 got=%b exp=%b", {a0, d0}, {4'b1100, 4'd1});
        end
        step(4'h0, POP);
        tests++;
        if ({a0, d0} !== {4'b1111, 4'd0}) begin
            fails++; $display("FAIL nested_pop2 got=%b exp=%b", {a0, d0}, {4'b1111, 4'd0});
        end
    endtask

    task automatic test_overflow();
        step(4'b1110, PUSH);
        step(4'b0111, PUSH);
        step(4'b0001, PUSH);
        tests++;
        if ({a1, d1, f1, o1} !== {4'b0110, 2'd2, 1'b1, 1'b1}) begin
            fails++; $display("FAIL ovf_small got=%b exp=%b", {a1, d1, f1, o1}, {4'b0110, 2'd2, 1'b1, 1'b1});
        end
        tests++;
        if ({a0, d0, f0, o0} !== {4'b0000, 4'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL ovf_large got=%b exp=%b", {a0, d0, f0, o0}, {4'b0000, 4'd3, 1'b0, 1'b0});
        end
        step(4'h0, RST);
    endtask

    task automatic test_underflow();
        step(4'h0, POP);
        tests++;
        if ({u0, a0, d0, u1} !== {1'b1, 4'hF, 4'd0, 1'b1}) begin
            fails++; $display("FAIL unf_pop got=%b exp=%b", {u0, a0, d0, u1}, {1'b1, 4'hF, 4'd0, 1'b1});
        end
        step(4'h0, CLR);
        tests++;
        if ({u0, u1} !== 2'b00) begin
            fails++; $display("FAIL unf_clear got=%b exp=%b", {u0, u1}, 2'b00);
        end
        step(4'h0, POP | CLR);
        tests++;
        if ({u0, u1} !== 2'b11) begin
            fails++; $display("FAIL unf_clr_race got=%b exp=%b", {u0, u1}, 2'b11);
        end
        step(4'h0, CLR);
    endtask

    task automatic test_multi_reset();
        step(4'b0011, PUSH);
        step(4'b0001, PUSH | POP);
        tests++;
        if ({m0, a0, d0, m1} !== {1'b1, 4'b0011, 4'd1, 1'b1}) begin
            fails++; $display("FAIL multi_op got=%b exp=%b", {m0, a0, d0, m1}, {1'b1, 4'b0011, 4'd1, 1'b1});
        end
        step(4'b0101, PUSH);
        step(4'h0, RST);
        tests++;
        if ({a0, d0, o0, u0, m0} !== {4'hF, 4'd0, 3'b000}) begin
            fails++; $display("FAIL multi_reset got=%b exp=%b", {a0, d0, o0, u0, m0}, {4'hF, 4'd0, 3'b000});
        end
    endtask

    task automatic test_pred_zero();
        step(4'b0000, PUSH);
        tests++;
        if ({a0, y0} !== {4'b0000, 1'b0}) begin
            fails++; $display("FAIL pred0_push got=%b exp=%b", {a0, y0}, {4'b0000, 1'b0});
        end
        step(4'h0, COMP);
        tests++;
        if ({a0, y0} !== {4'b1111, 1'b1}) begin
            fails++; $display("FAIL pred0_comp got=%b exp=%b", {a0, y0}, {4'b1111, 1'b1});
        end
        step(4'h0, POP);
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic [2:0] multi_tab [4];
        multi_tab = '{3'b011, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            op = NOP;
            if (r < 6)       op[0] = 1'b1;
            else if (r < 9)  op[1] = 1'b1;
            else if (r < 13) op[2] = 1'b1;
            else if (r == 13) op[2:0] = multi_tab[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) op[3] = 1'b1;
            if ($urandom_range(0, 63) == 0) op[4] = 1'b0;
            step(4'($urandom_range(0, 15)), op);
            tests++;
            if ({a0, d0, f0, e0, y0, o0, u0, m0} !== exp_vec(0)) begin
                fails++;
                $display("FAIL random_dut0 cycle %0d got=%b exp=%b", i, {a0, d0, f0, e0, y0, o0, u0, m0}, exp_vec(0));
            end
            tests++;
            if ({a1, 2'b00, d1, f1, e1, y1, o1, u1, m1} !== exp_vec(1)) begin
                fails++;
                $display("FAIL random_dut1 cycle %0d got=%b exp=%b", i, {a1, 2'b00, d1, f1, e1, y1, o1, u1, m1}, exp_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_nested();
        test_overflow();
        test_underflow();
        test_multi_reset();
        test_pred_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
